dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Transmit-side counterpart of the XADC capture path: takes 12-bit samples (e.g. FIR output) with a one-cycle valid strobe and serialises them to an external SPI DAC (DAC121S101-class, Pmod DA2).
- Sends one 16-bit frame per sample: 2 zero bits, 2 power-down mode bits, then 12 data bits, MSB first.
- Sits at the end of the ADC -> FIR -> DAC chain on the 78 MHz system clock.

Parameters:
- CLK_DIV, 4, SCLK half-period in system clocks (SCLK = 78 MHz / (2*CLK_DIV)); legal range >= 2, which keeps SCLK <= 19.5 MHz.
- SYNC_GAP, 2, number of SCLK half-periods for which sync_o is held high between frames; legal range >= 1.
- PD_MODE, 2'b00, power-down mode bits placed in frame bits [13:12]; 00 = normal operation.

Ports:
- clk_78MHz_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- data_i  input  12  unsigned straight-binary sample
- valid_i  input  1  one-cycle sample strobe, same semantics as the ADC ready_o
- busy_o  output  1  frame in progress (states LOAD/SHIFT/GAP)
- done_o  output  1  one-cycle pulse on the last cycle of GAP
- overrun_o  output  1  one-cycle pulse when a sample is discarded
- sclk_o  output  1  SPI clock; idles high
- sync_o  output  1  active-low frame sync (SYNC)
- sdata_o  output  1  serial data (DIN)

Behaviour:
- All outputs are registered.
- Reset values: sclk_o=1, sync_o=1, sdata_o=0, busy_o=0, done_o=0, overrun_o=0. FSM=IDLE; shift register, half-period counter and bit counter are cleared.
- Half-period counter: counts 0..CLK_DIV-1 and generates a tick at CLK_DIV-1. It is cleared on every state entry.
- FSM states:
  - IDLE: on valid_i, latch {2'b00, PD_MODE, data_i} into the 16-bit shift register and go to LOAD.
  - LOAD (CLK_DIV cycles): sync_o=0, sclk_o=1, sdata_o=frame[15]. On tick -> SHIFT with sclk_o=0. This is falling edge #1.
  - SHIFT: sclk_o toggles on each tick.
    - Rising edge (0->1): shift the register and present the next bit on sdata_o.
    - The DAC samples sdata_o on falling edges.
    - Bit counter increments on each falling edge.
    - After falling edge #16 and its low half-period: go to GAP, setting sclk_o=1 and sync_o=1 in the same cycle.
  - GAP (SYNC_GAP*CLK_DIV cycles): sync_o=1, sclk_o=1, sdata_o=0. done_o=1 on the final cycle, then -> IDLE.
- Timing with valid_i sampled at cycle T:
  - sync_o falls at T+1 and stays low for exactly 32*CLK_DIV cycles.
  - done_o pulses at T+(32+SYNC_GAP)*CLK_DIV; with defaults that is T+136.
  - busy_o is high from T+1 through the done_o cycle and low the cycle after.
- SCLK high and low phases are each exactly CLK_DIV cycles; sdata_o changes only on SCLK rising edges or at sync_o falling.
- Samples arriving while busy_o=1 are handled as described under Optional Feature.
- Reset mid-frame: outputs return to reset values on the next edge. sync_o rising before the 16th falling edge aborts the write in the DAC, so nothing partial is latched.
- valid_i asserted in the same cycle as reset_i is ignored.

Optional Feature:
- Macro: DAC_HOLD_BUF_EN.
- When defined:
  - One-entry holding register plus hold_valid flag.
  - valid_i while busy_o=1 stores data_i into the holding register.
  - If hold_valid is already set, the held sample is overwritten with the newer one and overrun_o pulses.
  - On the done_o cycle, if hold_valid is set (including a valid_i arriving in that same cycle), the FSM goes directly to LOAD with the held sample and clears hold_valid. There is no IDLE cycle, so busy_o stays high.
  - Reset clears hold_valid.
- When not defined:
  - No holding register.
  - valid_i while busy_o=1 (including the done_o cycle) is dropped and overrun_o pulses for that cycle.

Test Plan:
- Reset, then data_i=12'hA5C with valid_i at T (defaults). Expect:
  - sync_o low for 128 cycles.
  - 16 SCLK falling edges, each 8 cycles apart.
  - Bits captured at falling edges = 16'h0A5C.
  - done_o at T+136; busy_o low at T+137.
- CLK_DIV=2, PD_MODE=2'b11, data_i=12'hFFF. Expect captured frame 16'h3FFF, SCLK period 4 cycles, sync_o low for 64 cycles.
- Without DAC_HOLD_BUF_EN: second valid_i at T+50 with 12'h123. Expect overrun_o pulse at T+51, only one frame sent, busy_o low at T+137.
- With DAC_HOLD_BUF_EN: valid_i at T+50 (12'h111), then T+60 (12'h222). Expect:
  - overrun_o at T+61.
  - sync_o falls again at T+137 without an IDLE gap.
  - Second frame = 16'h0222.
- reset_i asserted at T+40 during SHIFT. Expect sync_o=1, sclk_o=1, busy_o=0 at T+41 and no done_o. A new valid_i at T+45 produces a complete, correct frame.
- Back-to-back valid_i asserted exactly in each done_o cycle, with the macro defined. Expect a continuous frame stream with sync_o high for exactly SYNC_GAP*CLK_DIV = 8 cycles between frames.

Source files
------------

// File: rtl/dac_spi_tx_if.sv
// Sample-in / SPI-out bundle for dac_spi_tx.
interface dac_spi_tx_if;
    logic [11:0] data_i;
    logic        valid_i;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;
    logic        sclk_o;
    logic        sync_o;
    logic        sdata_o;

    modport master (
        output data_i, valid_i,
        input  busy_o, done_o, overrun_o,
        input  sclk_o, sync_o, sdata_o
    );

    modport slave (
        input  data_i, valid_i,
        output busy_o, done_o, overrun_o,
        output sclk_o, sync_o, sdata_o
    );
endinterface

// File: rtl/dac_spi_tx.sv
// 16-bit SPI frame serialiser for a DAC121S101-class DAC.
// Optional one-entry sample holding buffer: DAC_HOLD_BUF_EN.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SYNC_GAP = 2,
    parameter logic [1:0]  PD_MODE  = 2'b00
) (
    input logic         clk_78MHz_i,
    input logic         reset_i,
    dac_spi_tx_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(SYNC_GAP + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   sr_q, sr_d;
    logic          sclk_q, sclk_d;
    logic          sync_q, sync_d;
    logic          sdata_q, sdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic          tick;
    logic          gap_end;
    logic          start;
    logic [11:0]   start_data;
    logic [15:0]   frame;
`ifdef DAC_HOLD_BUF_EN
    logic [11:0]   hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
`endif

    assign tick    = (cnt_q == CNT_LAST);
    assign gap_end = (state_q == GAP) && tick && (gap_q == GAP_LAST);
    assign frame   = {2'b00, PD_MODE, start_data};

    // Sample acceptance: decides whether a frame starts and what overruns.
    always_comb begin
        start      = 1'b0;
        start_data = bus.data_i;
        ovr_d      = 1'b0;
`ifdef DAC_HOLD_BUF_EN
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        if (state_q == IDLE) begin
            start = bus.valid_i;
        end else if (gap_end) begin
            start      = bus.valid_i || hold_v_q;
            start_data = bus.valid_i ? bus.data_i : hold_q;
            ovr_d      = bus.valid_i && hold_v_q;
            hold_v_d   = 1'b0;
        end else if (bus.valid_i) begin
            hold_d   = bus.data_i;
            hold_v_d = 1'b1;
            ovr_d    = hold_v_q;
        end
`else
        start = bus.valid_i && (state_q == IDLE);
        ovr_d = bus.valid_i && (state_q != IDLE);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        sclk_d  = 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = LOAD;
                    sr_d    = frame;
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    bit_d   = 5'd1;
                end
            end
            SHIFT: begin
                sclk_d = sclk_q;
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 5'd1;
                    end else if (bit_q == 5'd16) begin
                        state_d = GAP;
                        sclk_d  = 1'b1;
                        gap_d   = '0;
                    end else begin
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[14:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        state_d = start ? LOAD : IDLE;
                        if (start) begin
                            sr_d = frame;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        sync_d  = !(state_d == LOAD || state_d == SHIFT);
        sdata_d = sync_d ? 1'b0 : sr_d[15];
        busy_d  = (state_d != IDLE);
        // Registered pulse, so it is armed one cycle before GAP ends.
        done_d  = (state_q == GAP) && (gap_q == GAP_LAST)
                  && (cnt_q == CNT_PRE);
    end

    always_ff @(posedge clk_78MHz_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            sr_q     <= '0;
            sclk_q   <= 1'b1;
            sync_q   <= 1'b1;
            sdata_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef DAC_HOLD_BUF_EN
            hold_q   <= '0;
            hold_v_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            sr_q     <= sr_d;
            sclk_q   <= sclk_d;
            sync_q   <= sync_d;
            sdata_q  <= sdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
`ifdef DAC_HOLD_BUF_EN
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
`endif
        end
    end

    assign bus.sclk_o    = sclk_q;
    assign bus.sync_o    = sync_q;
    assign bus.sdata_o   = sdata_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.overrun_o = ovr_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: default instance plus a CLK_DIV=2, PD_MODE=11 one.
// DAC_HOLD_BUF_EN selects which overrun/hold scenarios are expected.
module tb_dac_spi_tx;
    localparam int DA = 4;
    localparam int GA = 2;
    localparam int DB = 2;
    localparam int GB = 2;
    localparam logic [1:0] PDA = 2'b00;
    localparam logic [1:0] PDB = 2'b11;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    dac_spi_tx_if ia();
    dac_spi_tx_if ib();

    dac_spi_tx #(.CLK_DIV(DA), .SYNC_GAP(GA), .PD_MODE(PDA)) dut_a (
        .clk_78MHz_i(clk), .reset_i(reset_i), .bus(ia)
    );
    dac_spi_tx #(.CLK_DIV(DB), .SYNC_GAP(GB), .PD_MODE(PDB)) dut_b (
        .clk_78MHz_i(clk), .reset_i(reset_i), .bus(ib)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dut;
        int          fall_t;
        int          low_len;
        int          nfalls;
        logic [15:0] bits;
        int          min_ph;
        int          max_ph;
    } frame_rec_t;

    typedef struct {
        int dut;
        int kind;
        int t;
    } event_rec_t;

    frame_rec_t fq[$];
    event_rec_t eq[$];

    logic [1:0] sclk_w, sync_w, sdata_w, busy_w, done_w, ovr_w;
    assign sclk_w  = {ib.sclk_o, ia.sclk_o};
    assign sync_w  = {ib.sync_o, ia.sync_o};
    assign sdata_w = {ib.sdata_o, ia.sdata_o};
    assign busy_w  = {ib.busy_o, ia.busy_o};
    assign done_w  = {ib.done_o, ia.done_o};
    assign ovr_w   = {ib.overrun_o, ia.overrun_o};

    logic [1:0]  sclk_p = 2'b11;
    logic [1:0]  sync_p = 2'b11;
    logic [1:0]  sdata_p = 2'b00;
    logic [1:0]  busy_p = 2'b00;
    int          fall_t[2];
    int          last_e[2];
    int          nfe[2];
    int          min_ph[2];
    int          max_ph[2];
    int          viol[2] = '{0, 0};
    logic [15:0] bits[2];
    int          ph;

    // Pin-level DAC model: frames are what a real DAC would capture.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sync_p[i] && !sync_w[i]) begin
                fall_t[i] = cyc;
                last_e[i] = cyc;
                nfe[i]    = 0;
                bits[i]   = '0;
                min_ph[i] = 1 << 20;
                max_ph[i] = 0;
            end else if (!sync_w[i]) begin
                if (sclk_w[i] != sclk_p[i]) begin
                    ph = cyc - last_e[i];
                    if (ph < min_ph[i]) min_ph[i] = ph;
                    if (ph > max_ph[i]) max_ph[i] = ph;
                    last_e[i] = cyc;
                    if (!sclk_w[i]) begin
                        bits[i] = {bits[i][14:0], sdata_p[i]};
                        nfe[i]++;
                    end
                end
                if (sdata_w[i] != sdata_p[i]
                    && !(sclk_w[i] && !sclk_p[i]))
                    viol[i]++;
            end else if (!sync_p[i]) begin
                ph = cyc - last_e[i];
                if (ph < min_ph[i]) min_ph[i] = ph;
                if (ph > max_ph[i]) max_ph[i] = ph;
                fq.push_back('{i, fall_t[i], cyc - fall_t[i],
                               nfe[i], bits[i], min_ph[i], max_ph[i]});
            end
            if (sync_w[i] && (sclk_w[i] !== 1'b1 || sdata_w[i] !== 1'b0))
                viol[i]++;
            if (done_w[i]) eq.push_back('{i, 0, cyc});
            if (ovr_w[i]) eq.push_back('{i, 1, cyc});
            if (busy_p[i] && !busy_w[i]) eq.push_back('{i, 2, cyc});
            sclk_p[i]  = sclk_w[i];
            sync_p[i]  = sync_w[i];
            sdata_p[i] = sdata_w[i];
            busy_p[i]  = busy_w[i];
        end
    end

    function automatic int ev_n(int d, int k);
        int n = 0;
        foreach (eq[j]) if (eq[j].dut == d && eq[j].kind == k) n++;
        return n;
    endfunction

    function automatic int ev_time(int d, int k, int idx);
        int n = 0;
        int r = -1;
        foreach (eq[j]) begin
            if (eq[j].dut == d && eq[j].kind == k) begin
                if (n == idx) r = eq[j].t;
                n++;
            end
        end
        return r;
    endfunction

    function automatic int fr_n(int d);
        int n = 0;
        foreach (fq[j]) if (fq[j].dut == d) n++;
        return n;
    endfunction

    function automatic frame_rec_t fr_get(int d, int idx);
        frame_rec_t r;
        int n = 0;
        r = '{-1, -1, -1, -1, 16'h0, -1, -1};
        foreach (fq[j]) begin
            if (fq[j].dut == d) begin
                if (n == idx) r = fq[j];
                n++;
            end
        end
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        fq.delete();
        eq.delete();
    endtask

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int d, logic [11:0] v, int c);
        wait_until(c);
        if (d == 0) begin
            ia.valid_i = 1'b1;
            ia.data_i  = v;
        end else begin
            ib.valid_i = 1'b1;
            ib.data_i  = v;
        end
        @(posedge clk);
        #1;
        ia.valid_i = 1'b0;
        ib.valid_i = 1'b0;
    endtask

    // One isolated sample; every expectation comes from the frame rules.
    task automatic run_one(int d, logic [11:0] v, string tag);
        int          t;
        int          dv;
        int          gp;
        logic [15:0] exp;
        frame_rec_t  f;
        dv  = (d == 0) ? DA : DB;
        gp  = (d == 0) ? GA : GB;
        exp = {2'b00, ((d == 0) ? PDA : PDB), v};
        clear();
        t = cyc + 1;
        send(d, v, t);
        wait_until(t + (32 + gp) * dv + 20);
        f = fr_get(d, 0);
        check({tag, "_nframes"}, fr_n(d), 1);
        check({tag, "_bits"}, f.bits, exp);
        check({tag, "_sync_fall"}, f.fall_t, t + 1);
        check({tag, "_sync_low"}, f.low_len, 32 * dv);
        check({tag, "_nfalls"}, f.nfalls, 16);
        check({tag, "_ph_min"}, f.min_ph, dv);
        check({tag, "_ph_max"}, f.max_ph, dv);
        check({tag, "_done_t"}, ev_time(d, 0, 0), t + (32 + gp) * dv);
        check({tag, "_ndone"}, ev_n(d, 0), 1);
        check({tag, "_busy_low"}, ev_time(d, 2, 0), t + (32 + gp) * dv + 1);
        check({tag, "_no_ovr"}, ev_n(d, 1), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        frame_rec_t  f;
        frame_rec_t  g;
        frame_rec_t  h;
        ia.valid_i = 1'b0;
        ia.data_i  = '0;
        ib.valid_i = 1'b0;
        ib.data_i  = '0;
        reset_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", ia.sclk_o, 1'b1);
        check("rst_sync", ia.sync_o, 1'b1);
        check("rst_sdata", ia.sdata_o, 1'b0);
        check("rst_busy", ia.busy_o, 1'b0);
        check("rst_done", ia.done_o, 1'b0);
        check("rst_ovr", ia.overrun_o, 1'b0);
        check("rst_b_sync", ib.sync_o, 1'b1);
        reset_i = 1'b0;
        @(posedge clk);
        #1;

        run_one(0, 12'hA5C, "a_a5c");
        run_one(1, 12'hFFF, "b_fff");
        for (int k = 0; k < 3; k++) begin
            run_one(0, 12'($urandom), "a_rnd");
            run_one(1, 12'($urandom), "b_rnd");
        end

`ifndef DAC_HOLD_BUF_EN
        clear();
        t = cyc + 1;
        send(0, 12'h456, t);
        send(0, 12'h123, t + 50);
        wait_until(t + 200);
        f = fr_get(0, 0);
        check("drop_nframes", fr_n(0), 1);
        check("drop_bits", f.bits, 16'h0456);
        check("drop_novr", ev_n(0, 1), 1);
        check("drop_ovr_t", ev_time(0, 1, 0), t + 51);
        check("drop_busy_low", ev_time(0, 2, 0), t + 137);

        clear();
        t = cyc + 1;
        send(0, 12'h0F0, t);
        send(0, 12'h321, t + 136);
        wait_until(t + 320);
        check("donecyc_nframes", fr_n(0), 1);
        check("donecyc_ovr_t", ev_time(0, 1, 0), t + 137);
        check("donecyc_busy_low", ev_time(0, 2, 0), t + 137);
`else
        clear();
        t = cyc + 1;
        send(0, 12'h789, t);
        send(0, 12'h111, t + 50);
        send(0, 12'h222, t + 60);
        wait_until(t + 320);
        f = fr_get(0, 0);
        g = fr_get(0, 1);
        check("hold_nframes", fr_n(0), 2);
        check("hold_f1_bits", f.bits, 16'h0789);
        check("hold_novr", ev_n(0, 1), 1);
        check("hold_ovr_t", ev_time(0, 1, 0), t + 61);
        check("hold_f2_fall", g.fall_t, t + 137);
        check("hold_f2_bits", g.bits, 16'h0222);
        check("hold_ndone", ev_n(0, 0), 2);
        check("hold_busy_low", ev_time(0, 2, 0), t + 273);

        clear();
        t = cyc + 1;
        send(0, 12'h1A1, t);
        send(0, 12'h2B2, t + 136);
        send(0, 12'h3C3, t + 272);
        wait_until(t + 460);
        f = fr_get(0, 0);
        g = fr_get(0, 1);
        h = fr_get(0, 2);
        check("b2b_nframes", fr_n(0), 3);
        check("b2b_bits1", f.bits, 16'h01A1);
        check("b2b_bits2", g.bits, 16'h02B2);
        check("b2b_bits3", h.bits, 16'h03C3);
        check("b2b_gap1", g.fall_t - (f.fall_t + f.low_len), GA * DA);
        check("b2b_gap2", h.fall_t - (g.fall_t + g.low_len), GA * DA);
        check("b2b_low3", h.low_len, 32 * DA);
        check("b2b_no_ovr", ev_n(0, 1), 0);
        check("b2b_busy_low", ev_time(0, 2, 0), t + 3 * 136 + 1);
`endif

        clear();
        t = cyc + 1;
        send(0, 12'h5A3, t);
        wait_until(t + 40);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        check("abort_sync", ia.sync_o, 1'b1);
        check("abort_sclk", ia.sclk_o, 1'b1);
        check("abort_busy", ia.busy_o, 1'b0);
        check("abort_sdata", ia.sdata_o, 1'b0);
        send(0, 12'h3C7, t + 45);
        wait_until(t + 45 + 200);
        f = fr_get(0, 0);
        g = fr_get(0, 1);
        check("abort_nframes", fr_n(0), 2);
        check("abort_partial", f.nfalls < 16, 1'b1);
        check("abort_ndone", ev_n(0, 0), 1);
        check("abort_done_t", ev_time(0, 0, 0), t + 45 + 136);
        check("abort_f2_fall", g.fall_t, t + 46);
        check("abort_f2_bits", g.bits, 16'h03C7);
        check("abort_f2_nfalls", g.nfalls, 16);

        clear();
        reset_i    = 1'b1;
        ia.valid_i = 1'b1;
        ia.data_i  = 12'h777;
        @(posedge clk);
        #1;
        reset_i    = 1'b0;
        ia.valid_i = 1'b0;
        check("rstvalid_busy", ia.busy_o, 1'b0);
        check("rstvalid_sync", ia.sync_o, 1'b1);
        wait_until(cyc + 40);
        check("rstvalid_nframes", fr_n(0), 0);

        check("pin_rules_a", viol[0], 0);
        check("pin_rules_b", viol[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
